// File: rtl/sobel_frame_ctrl.sv
// Frame-boundary controller for the Sobel pipeline: shadowed configuration committed at vsync,
// per-frame line/edge statistics, and optional frame-to-frame auto-threshold steering.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned DEFAULT_THR = 100,
  parameter int unsigned THR_MIN     = 40,
  parameter int unsigned THR_MAX     = 200,
  parameter int unsigned THR_STEP    = 4,
  parameter int unsigned TARGET_LO   = 3000,
  parameter int unsigned TARGET_HI   = 12000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             href,
  input  logic             binary_valid,
  input  logic             binary_pixel,
  input  logic             cfg_we,
  input  logic             cfg_sobel_enable,
  input  logic [7:0]       cfg_threshold,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_auto_en,
  output logic             sobel_enable,
  output logic [7:0]       edge_threshold,
  output logic [1:0]       threshold_mode,
  output logic             cfg_pending,
  output logic             frame_done,
  output logic [CNT_W-1:0] edge_count,
  output logic [9:0]       line_count,
  output logic             frame_err
);

  localparam logic [7:0]       DefaultThr = 8'(DEFAULT_THR);
  localparam logic [8:0]       ThrMin9    = 9'(THR_MIN);
  localparam logic [8:0]       ThrMax9    = 9'(THR_MAX);
  localparam logic [8:0]       ThrStep9   = 9'(THR_STEP);
  localparam logic [CNT_W-1:0] TargetLo   = CNT_W'(TARGET_LO);
  localparam logic [CNT_W-1:0] TargetHi   = CNT_W'(TARGET_HI);
  localparam logic [CNT_W-1:0] EdgeOne    = CNT_W'(1);
  localparam logic [9:0]       ImgHeight  = 10'(IMG_HEIGHT);
  localparam logic [9:0]       LineMax    = 10'h3ff;

  typedef enum logic [1:0] {StIdle, StActive, StEval, StCommit} state_e;

  state_e state_q, state_d;

  logic vsync_q, href_q;
  logic vsync_rise_q, vsync_rise_d;
  logic href_rise_q, href_rise_d;

  logic       sh_en_q, sh_en_d;
  logic [7:0] sh_thr_q, sh_thr_d;
  logic [1:0] sh_mode_q, sh_mode_d;
  logic       sh_auto_q, sh_auto_d;

  logic             sobel_enable_q, sobel_enable_d;
  logic [7:0]       thr_q, thr_d;
  logic [1:0]       mode_q, mode_d;
  logic             cfg_pending_q, cfg_pending_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic [9:0]       line_count_q, line_count_d;
  logic             frame_err_q, frame_err_d;

  logic [CNT_W-1:0] run_edges_q, run_edges_d;
  logic [9:0]       run_lines_q, run_lines_d;

  // 9-bit views of the threshold so step arithmetic never wraps before clamping.
  logic [8:0] thr_ext, thr_inc;
  assign thr_ext = {1'b0, thr_q};
  assign thr_inc = thr_ext + ThrStep9;

  always_comb begin
    state_d        = state_q;
    vsync_rise_d   = vsync & ~vsync_q;
    href_rise_d    = href & ~href_q;
    sh_en_d        = sh_en_q;
    sh_thr_d       = sh_thr_q;
    sh_mode_d      = sh_mode_q;
    sh_auto_d      = sh_auto_q;
    sobel_enable_d = sobel_enable_q;
    thr_d          = thr_q;
    mode_d         = mode_q;
    cfg_pending_d  = cfg_pending_q;
    frame_done_d   = 1'b0;
    edge_count_d   = edge_count_q;
    line_count_d   = line_count_q;
    frame_err_d    = frame_err_q;
    run_edges_d    = run_edges_q;
    run_lines_d    = run_lines_q;

    if (cfg_we) begin
      sh_en_d   = cfg_sobel_enable;
      sh_thr_d  = cfg_threshold;
      sh_mode_d = cfg_mode;
      sh_auto_d = cfg_auto_en;
    end

    unique case (state_q)
      StIdle: begin
        if (vsync_rise_q) state_d = StCommit;
      end
      StActive: begin
        if (href_rise_q && (run_lines_q != LineMax)) run_lines_d = run_lines_q + 10'd1;
        if (binary_valid && binary_pixel && (run_edges_q != '1)) begin
          run_edges_d = run_edges_q + EdgeOne;
        end
        if (vsync_rise_q) state_d = StEval;
      end
      StEval: begin
        edge_count_d = run_edges_q;
        line_count_d = run_lines_q;
        frame_err_d  = (run_lines_q != ImgHeight);
        frame_done_d = 1'b1;
        if (sh_auto_q) begin
          if (run_edges_q > TargetHi) begin
            thr_d = (thr_inc > ThrMax9) ? ThrMax9[7:0] : thr_inc[7:0];
          end else if (run_edges_q < TargetLo) begin
            thr_d = (thr_ext < (ThrMin9 + ThrStep9)) ? ThrMin9[7:0] : 8'(thr_ext - ThrStep9);
          end
        end
        state_d = StCommit;
      end
      StCommit: begin
        sobel_enable_d = sh_en_q;
        mode_d         = sh_mode_q;
        // In auto mode the active threshold carries over, so enabling auto starts from it.
        if (!sh_auto_q) thr_d = sh_thr_q;
        run_edges_d    = '0;
        run_lines_d    = '0;
        cfg_pending_d  = 1'b0;
        state_d        = StActive;
      end
      default: state_d = StIdle;
    endcase

    // A write landing in the commit cycle stays pending for the next frame.
    if (cfg_we) cfg_pending_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      vsync_q        <= 1'b0;
      href_q         <= 1'b0;
      vsync_rise_q   <= 1'b0;
      href_rise_q    <= 1'b0;
      sh_en_q        <= 1'b0;
      sh_thr_q       <= DefaultThr;
      sh_mode_q      <= 2'd0;
      sh_auto_q      <= 1'b0;
      sobel_enable_q <= 1'b0;
      thr_q          <= DefaultThr;
      mode_q         <= 2'd0;
      cfg_pending_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      edge_count_q   <= '0;
      line_count_q   <= '0;
      frame_err_q    <= 1'b0;
      run_edges_q    <= '0;
      run_lines_q    <= '0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync;
      href_q         <= href;
      vsync_rise_q   <= vsync_rise_d;
      href_rise_q    <= href_rise_d;
      sh_en_q        <= sh_en_d;
      sh_thr_q       <= sh_thr_d;
      sh_mode_q      <= sh_mode_d;
      sh_auto_q      <= sh_auto_d;
      sobel_enable_q <= sobel_enable_d;
      thr_q          <= thr_d;
      mode_q         <= mode_d;
      cfg_pending_q  <= cfg_pending_d;
      frame_done_q   <= frame_done_d;
      edge_count_q   <= edge_count_d;
      line_count_q   <= line_count_d;
      frame_err_q    <= frame_err_d;
      run_edges_q    <= run_edges_d;
      run_lines_q    <= run_lines_d;
    end
  end

  assign sobel_enable   = sobel_enable_q;
  assign edge_threshold = thr_q;
  assign threshold_mode = mode_q;
  assign cfg_pending    = cfg_pending_q;
  assign frame_done     = frame_done_q;
  assign edge_count     = edge_count_q;
  assign line_count     = line_count_q;
  assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Randomized bench for sobel_frame_ctrl: an event-timed frame model predicts every output each
// cycle, and literal expectations pin the headline scenarios.
module tb_sobel_frame_ctrl;

  localparam int IMG_HEIGHT = 480;
  localparam int DEFAULT_THR = 100;
  localparam int THR_MIN = 40;
  localparam int THR_MAX = 200;
  localparam int THR_STEP = 4;
  localparam int TARGET_LO = 3000;
  localparam int TARGET_HI = 12000;
  localparam int CNT_W = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync, href, binary_valid, binary_pixel;
  logic cfg_we, cfg_sobel_enable, cfg_auto_en;
  logic [7:0] cfg_threshold;
  logic [1:0] cfg_mode;
  logic sobel_enable, cfg_pending, frame_done, frame_err;
  logic [7:0] edge_threshold;
  logic [1:0] threshold_mode;
  logic [CNT_W-1:0] edge_count;
  logic [9:0] line_count;

  always #5 clk = ~clk;

  sobel_frame_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .vsync            (vsync),
    .href             (href),
    .binary_valid     (binary_valid),
    .binary_pixel     (binary_pixel),
    .cfg_we           (cfg_we),
    .cfg_sobel_enable (cfg_sobel_enable),
    .cfg_threshold    (cfg_threshold),
    .cfg_mode         (cfg_mode),
    .cfg_auto_en      (cfg_auto_en),
    .sobel_enable     (sobel_enable),
    .edge_threshold   (edge_threshold),
    .threshold_mode   (threshold_mode),
    .cfg_pending      (cfg_pending),
    .frame_done       (frame_done),
    .edge_count       (edge_count),
    .line_count       (line_count),
    .frame_err        (frame_err)
  );

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;
  int fd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: frames open at a commit and close at the next vsync rise; boundary events
  // are scheduled by absolute cycle number relative to that rise.
  int  m_cyc, t_eval, t_commit, m_edges, m_lines;
  bit  in_frame, pv, ph, m_vr, m_hr;
  bit  sh_en, sh_auto;
  int  sh_thr, sh_mode;
  bit  exp_en, exp_pend, exp_fd, exp_err;
  int  exp_thr, exp_mode, exp_edge, exp_line;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; t_eval = -1; t_commit = -1; m_edges = 0; m_lines = 0;
      in_frame = 0; pv = 0; ph = 0;
      sh_en = 0; sh_auto = 0; sh_thr = DEFAULT_THR; sh_mode = 0;
      exp_en = 0; exp_thr = DEFAULT_THR; exp_mode = 0; exp_pend = 0; exp_fd = 0;
      exp_edge = 0; exp_line = 0; exp_err = 0;
    end else begin
      m_cyc++;
      m_vr = vsync && !pv;
      m_hr = href && !ph;
      pv = vsync;
      ph = href;
      exp_fd = 0;
      if (in_frame) begin
        if (m_hr && m_lines < 1023) m_lines++;
        if (binary_valid && binary_pixel && m_edges < (1 << CNT_W) - 1) m_edges++;
      end
      if (m_vr) begin
        if (in_frame) begin
          t_eval = m_cyc + 2;
          t_commit = m_cyc + 3;
          in_frame = 0;
        end else if (m_cyc > t_commit) begin
          t_commit = m_cyc + 2;
        end
      end
      if (m_cyc == t_eval) begin
        exp_edge = m_edges;
        exp_line = m_lines;
        exp_err = (m_lines != IMG_HEIGHT);
        exp_fd = 1;
        if (sh_auto) begin
          if (m_edges > TARGET_HI) exp_thr = (exp_thr + THR_STEP > THR_MAX) ? THR_MAX
                                                                          : exp_thr + THR_STEP;
          else if (m_edges < TARGET_LO) exp_thr = (exp_thr - THR_STEP < THR_MIN) ? THR_MIN
                                                                              : exp_thr - THR_STEP;
        end
      end
      if (m_cyc == t_commit) begin
        exp_en = sh_en;
        exp_mode = sh_mode;
        if (!sh_auto) exp_thr = sh_thr;
        exp_pend = 0;
        in_frame = 1;
        m_edges = 0;
        m_lines = 0;
      end
      if (cfg_we) begin
        sh_en = cfg_sobel_enable;
        sh_thr = cfg_threshold;
        sh_mode = cfg_mode;
        sh_auto = cfg_auto_en;
        exp_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("sobel_enable", sobel_enable, exp_en);
      check("edge_threshold", edge_threshold, exp_thr);
      check("threshold_mode", threshold_mode, exp_mode);
      check("cfg_pending", cfg_pending, exp_pend);
      check("frame_done", frame_done, exp_fd);
      check("edge_count", edge_count, exp_edge);
      check("line_count", line_count, exp_line);
      check("frame_err", frame_err, exp_err);
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  task automatic drive(input bit h, input bit bv, input bit bp);
    @(negedge clk);
    href = h;
    binary_valid = bv;
    binary_pixel = bp;
  endtask

  task automatic drive_nonedge(input bit h);
    int r;
    r = $urandom_range(0, 2);
    drive(h, r == 1, r == 2);
  endtask

  task automatic run_frame(input int lines, input int edges, input int hi_len);
    int rem;
    rem = edges;
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < hi_len; c++) begin
        if (rem > 0 && ($urandom % 4) != 0) begin
          drive(1'b1, 1'b1, 1'b1);
          rem--;
        end else begin
          drive_nonedge(1'b1);
        end
      end
      drive_nonedge(1'b0);
      drive_nonedge(1'b0);
    end
    while (rem > 0) begin
      if (($urandom % 8) == 0) drive_nonedge(1'b0);
      else begin
        drive(1'b0, 1'b1, 1'b1);
        rem--;
      end
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_cfg(input bit en, input int thr, input int mode, input bit auto_en);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_sobel_enable = en;
    cfg_threshold = 8'(thr);
    cfg_mode = 2'(mode);
    cfg_auto_en = auto_en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Vsync pulse; optionally strobes cfg_we so it is sampled on the commit edge of an active frame.
  task automatic boundary(input bit we, input bit en, input int thr, input int mode,
                          output int fd_delta);
    int fd0;
    fd0 = fd_cnt;
    @(negedge clk);
    vsync = 1'b1;
    href = 1'b0;
    binary_valid = 1'b0;
    binary_pixel = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      if (we && i == 2) begin
        cfg_we = 1'b1;
        cfg_sobel_enable = en;
        cfg_threshold = 8'(thr);
        cfg_mode = 2'(mode);
        cfg_auto_en = 1'b0;
      end
      if (i == 5) vsync = 1'b0;
    end
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    fd_delta = fd_cnt - fd0;
  endtask

  task automatic check_cfg(input string tag, input int en, input int thr, input int mode,
                           input int pend);
    check({tag, "_en"}, sobel_enable, en);
    check({tag, "_thr"}, edge_threshold, thr);
    check({tag, "_mode"}, threshold_mode, mode);
    check({tag, "_pend"}, cfg_pending, pend);
  endtask

  task automatic check_stats(input string tag, input int edges, input int lines, input int err,
                             input int fd);
    check({tag, "_edges"}, edge_count, edges);
    check({tag, "_lines"}, line_count, lines);
    check({tag, "_err"}, frame_err, err);
    check({tag, "_fd_pulses"}, fd, 1);
  endtask

  initial begin
    int fd;
    int want;
    vsync = 0; href = 0; binary_valid = 0; binary_pixel = 0;
    cfg_we = 0; cfg_sobel_enable = 0; cfg_threshold = 0; cfg_mode = 0; cfg_auto_en = 0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check_cfg("reset", 0, DEFAULT_THR, 0, 0);
    check_stats("reset", 0, 0, 0, 1);

    // Shadow write is held until the first frame boundary.
    write_cfg(1'b1, 80, 1, 1'b0);
    @(negedge clk);
    check_cfg("shadow_held", 0, DEFAULT_THR, 0, 1);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("first_commit", 1, 80, 1, 0);
    check("first_commit_no_fd", fd, 0);

    run_frame(480, 5000, 10);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_stats("full_frame", 5000, 480, 0, fd);

    run_frame(479, 2000, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_stats("short_frame", 2000, 479, 1, fd);
    run_frame(480, 3000, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_stats("recover_frame", 3000, 480, 0, fd);

    // Auto mode seeded from a manually committed 196.
    write_cfg(1'b1, 196, 1, 1'b0);
    run_frame(10, 50, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("manual196", 1, 196, 1, 0);
    write_cfg(1'b1, 7, 1, 1'b1);
    run_frame(5, 20000, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("auto_up", 1, 200, 1, 0);
    run_frame(5, 20000, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("auto_hold_max", 1, 200, 1, 0);
    for (int i = 1; i <= 41; i++) begin
      run_frame(3, 100, 4);
      boundary(1'b0, 1'b0, 0, 0, fd);
      want = (200 - 4 * i < THR_MIN) ? THR_MIN : 200 - 4 * i;
      check("auto_down_thr", edge_threshold, want);
    end
    check("auto_floor", edge_threshold, 40);

    // Write landing on the commit edge.
    write_cfg(1'b1, 120, 2, 1'b0);
    run_frame(4, 10, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("manual120", 1, 120, 2, 0);
    run_frame(4, 10, 4);
    boundary(1'b1, 1'b0, 60, 3, fd);
    check_cfg("we_in_commit", 1, 120, 2, 1);
    run_frame(4, 10, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("we_next_frame", 0, 60, 3, 0);

    // Asynchronous reset in the middle of a frame.
    run_frame(6, 40, 4);
    drive(1'b1, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_cfg("midrst", 0, DEFAULT_THR, 0, 0);
    check("midrst_fd", frame_done, 0);
    check("midrst_edges", edge_count, 0);
    check("midrst_lines", line_count, 0);
    check("midrst_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) drive(i % 5 != 4, 1'b1, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 1'b0);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_cfg("post_rst_commit", 0, DEFAULT_THR, 0, 0);
    check("post_rst_no_fd", fd, 0);
    run_frame(7, 123, 4);
    boundary(1'b0, 1'b0, 0, 0, fd);
    check_stats("post_rst_frame", 123, 7, 1, fd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
